// File: rtl/phase_meas_sched.sv
// Measurement scheduler for the 60 MHz phase detector: settle, collect 2^AVG_LOG2
// zero-crossing phases, and emit their wrap-aware circular mean over valid/ready.
module phase_meas_sched #(
    parameter int          AVG_LOG2    = 3,
    parameter logic [15:0] SETTLE_CYC  = 16'd256,
    parameter logic [23:0] TIMEOUT_CYC = 24'd600000
) (
    input  logic        clk_60m,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        phase_strobe,
    input  logic [11:0] phase_12bit,
    output logic        det_enable,
    output logic        busy,
    output logic [11:0] res_phase,
    output logic [7:0]  res_nsamp,
    output logic        res_timeout,
    output logic        res_valid,
    input  logic        res_ready
);

    localparam int         SW      = 13 + AVG_LOG2;
    localparam logic [8:0] N_SAMP  = 9'(1 << AVG_LOG2);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_COLLECT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]           state;
    logic [15:0]          settle_cnt;
    logic [23:0]          to_cnt;
    logic [7:0]           n;
    logic [11:0]          ref_ph;
    logic signed [SW-1:0] sum;

    logic [11:0]          delta;
    logic [11:0]          ref_next;
    logic signed [SW-1:0] sum_next;
    logic [11:0]          mean_lo;
    logic [8:0]           n_inc;

    // The first accepted strobe becomes the reference; later ones accumulate their
    // signed shortest-path offset from it, so the mean is immune to the 0/4095 wrap.
    always_comb begin
        delta    = phase_12bit - ref_ph;
        ref_next = (n == 8'd0) ? phase_12bit : ref_ph;
        sum_next = (n == 8'd0) ? '0 : sum + {{(SW-12){delta[11]}}, delta};
        mean_lo  = 12'(sum_next >>> AVG_LOG2);
        n_inc    = {1'b0, n} + 9'd1;
    end

    assign det_enable = (state == S_SETTLE) || (state == S_COLLECT);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk_60m or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            settle_cnt  <= '0;
            to_cnt      <= '0;
            n           <= '0;
            ref_ph      <= '0;
            sum         <= '0;
            res_phase   <= '0;
            res_nsamp   <= '0;
            res_timeout <= 1'b0;
            res_valid   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state      <= S_SETTLE;
                        settle_cnt <= '0;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (settle_cnt == SETTLE_CYC - 16'd1) begin
                        state  <= S_COLLECT;
                        to_cnt <= '0;
                        n      <= '0;
                        sum    <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end
                S_COLLECT: begin
                    // Timeout is checked first so a coincident strobe is discarded.
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (to_cnt == TIMEOUT_CYC - 24'd1) begin
                        state       <= S_DONE;
                        res_valid   <= 1'b1;
                        res_timeout <= 1'b1;
                        res_nsamp   <= n;
                        res_phase   <= (n != 8'd0) ? ref_ph : 12'd0;
                    end else begin
                        to_cnt <= to_cnt + 24'd1;
                        if (phase_strobe) begin
                            ref_ph <= ref_next;
                            sum    <= sum_next;
                            n      <= n_inc[7:0];
                            if (n_inc == N_SAMP) begin
                                state       <= S_DONE;
                                res_valid   <= 1'b1;
                                res_timeout <= 1'b0;
                                res_nsamp   <= n_inc[7:0];
                                res_phase   <= ref_next + mean_lo;
                            end
                        end
                    end
                end
                default: begin
                    if (abort || res_ready) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_meas_sched.sv
// Bench for phase_meas_sched: two instances (8-sample and 4-sample averaging) checked
// every cycle against a queue-of-phases model, with hand-computed results pinning the model.
module tb_phase_meas_sched;

    localparam logic [15:0] SETTLE = 16'd4;
    localparam logic [23:0] TMO    = 24'd1000;

    logic        clk;
    logic        rst;
    logic [1:0]  start, abort, strobe, ready;
    logic [11:0] phase_in [2];

    logic [1:0]  d_det, d_busy, d_to, d_valid;
    logic [11:0] d_phase [2];
    logic [7:0]  d_nsamp [2];

    int vectors    = 0;
    int miscompares = 0;

    int m_mode [2];
    int m_cnt  [2];
    int m_n    [2];
    int m_ph   [2][128];
    int e_phase [2];
    int e_nsamp [2];
    int e_to    [2];

    logic [1:0] pin_en;
    int pin_phase [2];
    int pin_nsamp [2];
    int pin_to    [2];

    phase_meas_sched #(.AVG_LOG2(3), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut_a (
        .clk_60m(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
        .phase_strobe(strobe[0]), .phase_12bit(phase_in[0]),
        .det_enable(d_det[0]), .busy(d_busy[0]), .res_phase(d_phase[0]),
        .res_nsamp(d_nsamp[0]), .res_timeout(d_to[0]), .res_valid(d_valid[0]),
        .res_ready(ready[0])
    );

    phase_meas_sched #(.AVG_LOG2(2), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut_b (
        .clk_60m(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
        .phase_strobe(strobe[1]), .phase_12bit(phase_in[1]),
        .det_enable(d_det[1]), .busy(d_busy[1]), .res_phase(d_phase[1]),
        .res_nsamp(d_nsamp[1]), .res_timeout(d_to[1]), .res_valid(d_valid[1]),
        .res_ready(ready[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Circular mean: signed shortest offsets from the first phase, floor-divided by count.
    function automatic int circ_mean(int i, int cnt);
        int r, s, d, q;
        r = m_ph[i][0];
        s = 0;
        for (int k = 0; k < cnt; k++) begin
            d = (((m_ph[i][k] - r) % 4096) + 4096) % 4096;
            if (d >= 2048) d = d - 4096;
            s = s + d;
        end
        q = s / cnt;
        if (s < 0 && q * cnt != s) q = q - 1;
        return (((r + q) % 4096) + 4096) % 4096;
    endfunction

    // Model modes: 0 idle, 1 settling, 2 collecting, 3 result pending.
    task automatic model_step(int i);
        int nsamp;
        nsamp = (i == 0) ? 8 : 4;
        if (rst) begin
            m_mode[i] = 0; m_cnt[i] = 0; m_n[i] = 0;
            e_phase[i] = 0; e_nsamp[i] = 0; e_to[i] = 0;
        end else begin
            case (m_mode[i])
                0: if (start[i] && !abort[i]) begin m_mode[i] = 1; m_cnt[i] = 0; end
                1: begin
                    if (abort[i]) m_mode[i] = 0;
                    else begin
                        m_cnt[i]++;
                        if (m_cnt[i] == int'(SETTLE)) begin m_mode[i] = 2; m_cnt[i] = 0; m_n[i] = 0; end
                    end
                end
                2: begin
                    if (abort[i]) m_mode[i] = 0;
                    else begin
                        m_cnt[i]++;
                        if (m_cnt[i] == int'(TMO)) begin
                            m_mode[i] = 3; e_to[i] = 1; e_nsamp[i] = m_n[i];
                            e_phase[i] = (m_n[i] > 0) ? m_ph[i][0] : 0;
                        end else if (strobe[i]) begin
                            m_ph[i][m_n[i]] = int'(phase_in[i]);
                            m_n[i]++;
                            if (m_n[i] == nsamp) begin
                                m_mode[i] = 3; e_to[i] = 0; e_nsamp[i] = nsamp;
                                e_phase[i] = circ_mean(i, nsamp);
                            end
                        end
                    end
                end
                default: if (abort[i] || ready[i]) m_mode[i] = 0;
            endcase
        end
    endtask

    task automatic check_output(string name, int i, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s[%0d] t=%0t got %0d expected %0d", name, i, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) model_step(i);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check_output("det_enable", i, int'(d_det[i]), (m_mode[i] == 1 || m_mode[i] == 2) ? 1 : 0);
                check_output("busy", i, int'(d_busy[i]), (m_mode[i] != 0) ? 1 : 0);
                check_output("res_valid", i, int'(d_valid[i]), (m_mode[i] == 3) ? 1 : 0);
                check_output("res_phase", i, int'(d_phase[i]), e_phase[i]);
                check_output("res_nsamp", i, int'(d_nsamp[i]), e_nsamp[i]);
                check_output("res_timeout", i, int'(d_to[i]), e_to[i]);
                if (pin_en[i] && m_mode[i] == 3) begin
                    check_output("pin_model_phase", i, e_phase[i], pin_phase[i]);
                    check_output("pin_dut_phase", i, int'(d_phase[i]), pin_phase[i]);
                    check_output("pin_dut_nsamp", i, int'(d_nsamp[i]), pin_nsamp[i]);
                    check_output("pin_dut_timeout", i, int'(d_to[i]), pin_to[i]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(int k);
        repeat (k) tick();
    endtask

    task automatic do_start(int i);
        start[i] = 1'b1; tick(); start[i] = 1'b0;
    endtask

    task automatic strobe_in(int i, int p);
        strobe[i] = 1'b1; phase_in[i] = 12'(p); tick(); strobe[i] = 1'b0;
    endtask

    task automatic set_pin(int i, int ph, int ns, int to);
        pin_phase[i] = ph; pin_nsamp[i] = ns; pin_to[i] = to; pin_en[i] = 1'b1;
    endtask

    task automatic accept(int i);
        ready[i] = 1'b1; tick(); ready[i] = 1'b0;
        pin_en[i] = 1'b0;
        wait_cycles(3);
    endtask

    task automatic apply_stimulus(int i, int p0, int p1, int p2, int p3);
        do_start(i);
        wait_cycles(int'(SETTLE));
        strobe_in(i, p0); wait_cycles(2);
        strobe_in(i, p1);
        strobe_in(i, p2); wait_cycles(1);
        strobe_in(i, p3);
        wait_cycles(4);
    endtask

    initial begin
        rst = 1'b1;
        start = '0; abort = '0; strobe = '0; ready = '0; pin_en = '0;
        phase_in[0] = '0; phase_in[1] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_cycles(2);

        $display("[TB] 8-sample measurement with strobes during settle and a stalled consumer");
        set_pin(0, 1000, 8, 0);
        do_start(0);
        strobe_in(0, 3000); strobe_in(0, 3000);
        wait_cycles(int'(SETTLE) - 2);
        for (int k = 0; k < 8; k++) begin
            strobe_in(0, 1000);
            if (k % 2 == 0) wait_cycles(1);
        end
        for (int k = 0; k < 50; k++) begin
            if (k % 10 == 5) do_start(0);
            else tick();
        end
        accept(0);

        $display("[TB] wrap-up and negative-offset averages");
        set_pin(1, 0, 4, 0);
        apply_stimulus(1, 4090, 4094, 2, 6);
        accept(1);
        set_pin(1, 4, 4, 0);
        apply_stimulus(1, 10, 6, 2, 4094);
        accept(1);

        $display("[TB] timeout with three strobes and with none");
        set_pin(1, 300, 3, 1);
        do_start(1);
        wait_cycles(int'(SETTLE));
        strobe_in(1, 300); wait_cycles(5);
        strobe_in(1, 310); strobe_in(1, 4090);
        wait_cycles(int'(TMO) + 5);
        accept(1);
        set_pin(1, 0, 0, 1);
        do_start(1);
        wait_cycles(int'(SETTLE) + int'(TMO) + 5);
        accept(1);

        $display("[TB] abort in collect, start with abort in idle, then a clean run");
        do_start(1);
        wait_cycles(int'(SETTLE));
        strobe_in(1, 1); strobe_in(1, 2);
        abort[1] = 1'b1; tick(); abort[1] = 1'b0;
        wait_cycles(3);
        start[1] = 1'b1; abort[1] = 1'b1; tick(); start[1] = 1'b0; abort[1] = 1'b0;
        wait_cycles(6);
        set_pin(1, 250, 4, 0);
        apply_stimulus(1, 100, 200, 300, 400);
        accept(1);

        $display("[TB] small positive bias, result dropped by abort");
        set_pin(1, 5, 4, 0);
        apply_stimulus(1, 5, 5, 5, 6);
        abort[1] = 1'b1; tick(); abort[1] = 1'b0;
        pin_en[1] = 1'b0;
        wait_cycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
